pipe_stage_chain: RTL and testbench

// Parametrised pipeline-register chain, successor to the single hold-enable 32-bit register.

---
 rtl/pipe_stage_chain.sv | 91 +++++++++
 tb/tb_pipe_stage_chain.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// Valid/ready pipeline register chain with bubble collapse, global stall and flush.
// Stage DEPTH-1 drives the output; each stage is one pipe_stage_chain_stage instance.

module pipe_stage_chain_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             stall,
   input  logic             adv,
   input  logic             src_v,
   input  logic [WIDTH-1:0] src_d,
   output logic             v,
   output logic [WIDTH-1:0] d
);

   // Data only loads from a valid source so an empty slot keeps its last payload.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v <= 1'b0;
         d <= '0;
      end else if (flush) begin
         v <= 1'b0;
      end else if (!stall && adv) begin
         v <= src_v;
         if (src_v) d <= src_d;
      end
   end

endmodule

module pipe_stage_chain #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] occupancy
);

   logic [DEPTH-1:0]            vld;
   logic [DEPTH-1:0]            adv;
   logic [DEPTH-1:0]            src_v;
   logic [DEPTH-1:0][WIDTH-1:0] src_d;
   logic [DEPTH-1:0][WIDTH-1:0] dat;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      // A stage is blocked only when it and every stage after it are full and the sink stalls.
      assign adv[i] = out_ready | ~(&vld[DEPTH-1:i]);

      if (i == 0) begin : g_head
         assign src_v[i] = in_valid;
         assign src_d[i] = in_data;
      end else begin : g_body
         assign src_v[i] = vld[i-1];
         assign src_d[i] = dat[i-1];
      end

      pipe_stage_chain_stage #(.WIDTH(WIDTH)) u_stage (
         .clk   (clk),
         .reset (reset),
         .flush (flush),
         .stall (stall),
         .adv   (adv[i]),
         .src_v (src_v[i]),
         .src_d (src_d[i]),
         .v     (vld[i]),
         .d     (dat[i])
      );
   end

   assign in_ready  = reset & adv[0] & ~stall & ~flush;
   assign out_valid = vld[DEPTH-1] & ~stall & ~flush;
   assign out_data  = dat[DEPTH-1];

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) occupancy = occupancy + CNT_W'(vld[i]);
   end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (DEPTH=3): slot/queue model checked every cycle
// plus hand-computed literal expectations.

module tb_pipe_stage_chain;

   localparam int W = 16;
   localparam int D = 3;

   logic         clk = 1'b0;
   logic         reset, stall, flush, in_valid, out_ready;
   logic [W-1:0] in_data;
   logic         in_ready, out_valid;
   logic [W-1:0] out_data;
   logic [1:0]   occupancy;

   int errors = 0;
   int checks = 0;

   // Model: which slots hold items, and the items themselves oldest-first.
   bit   [D-1:0] mv;
   logic [W-1:0] sbq[$];

   pipe_stage_chain #(.WIDTH(W), .DEPTH(D)) dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int mcount();
      int n = 0;
      for (int i = 0; i < D; i++) n += int'(mv[i]);
      return n;
   endfunction

   task automatic sample();
      bit live;
      @(negedge clk);
      live = reset & ~stall & ~flush;
      chk("model in_ready", 32'(in_ready), 32'(live & (mcount() < D || out_ready)));
      chk("model out_valid", 32'(out_valid), 32'(live & mv[D-1]));
      chk("model occupancy", 32'(occupancy), 32'(mcount()));
      if (live && mv[D-1] && sbq.size() > 0) chk("model out_data", 32'(out_data), 32'(sbq[0]));
   endtask

   task automatic step();
      bit         pop, acc;
      bit [D-1:0] nv;
      @(posedge clk);
      if (reset && flush) begin
         mv = '0;
         sbq.delete();
      end else if (reset && !stall) begin
         pop = mv[D-1] & out_ready;
         acc = in_valid & (mcount() < D || out_ready);
         if (pop) void'(sbq.pop_front());
         nv = '0;
         // Each item advances one slot if the slot ahead is free after later items moved.
         for (int i = D - 1; i >= 0; i--) begin
            if (mv[i] && !(i == D - 1 && pop)) begin
               if (i < D - 1 && !nv[i+1]) nv[i+1] = 1'b1;
               else                       nv[i]   = 1'b1;
            end
         end
         if (acc) begin
            nv[0] = 1'b1;
            sbq.push_back(in_data);
         end
         mv = nv;
      end
      #1;
   endtask

   task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
   endtask

   task automatic cyc();
      sample();
      step();
   endtask

   logic [W-1:0] items[6];

   initial begin
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
      drive(1'b1, 16'h1234, 1'b1);
      mv = '0;
      #2;
      chk("reset out_valid", 32'(out_valid), 0);
      chk("reset occupancy", 32'(occupancy), 0);
      chk("reset out_data", 32'(out_data), 0);
      chk("reset in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Back-to-back stream, out_ready=1: A leaves on cycle 3, occupancy holds at 3.
      items = '{16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h000E, 16'h000F};
      for (int k = 0; k < 9; k++) begin
         drive(k < 6, (k < 6) ? items[k] : 16'h0, 1'b1);
         sample();
         if (k >= 3) begin
            chk("stream out_valid", 32'(out_valid), 1);
            chk("stream out_data", 32'(out_data), 32'(items[k-3]));
         end
         if (k >= 3 && k < 6) chk("stream occupancy", 32'(occupancy), 3);
         step();
      end

      // Backpressure: 4th item refused until out_ready rises.
      drive(1'b1, 16'h0011, 1'b0); cyc();
      drive(1'b1, 16'h0022, 1'b0); cyc();
      drive(1'b1, 16'h0033, 1'b0); cyc();
      drive(1'b1, 16'h0044, 1'b0);
      sample();
      chk("full in_ready", 32'(in_ready), 0);
      chk("full occupancy", 32'(occupancy), 3);
      step();
      drive(1'b1, 16'h0044, 1'b1);
      sample();
      chk("full release in_ready", 32'(in_ready), 1);
      chk("full release out_data", 32'(out_data), 16'h0011);
      step();
      for (int k = 0; k < 3; k++) begin drive(1'b0, 16'h0, 1'b1); cyc(); end

      // Bubble: build v=1,0,1 then collapse to 1,1,1.
      drive(1'b1, 16'h0A01, 1'b0); cyc();
      drive(1'b0, 16'h0, 1'b0);    cyc();
      drive(1'b0, 16'h0, 1'b0);    cyc();
      drive(1'b1, 16'h0A02, 1'b0); cyc();
      drive(1'b1, 16'h0A03, 1'b0);
      sample();
      chk("bubble in_ready", 32'(in_ready), 1);
      chk("bubble occupancy", 32'(occupancy), 2);
      step();
      drive(1'b0, 16'h0, 1'b0);
      sample();
      chk("bubble filled occupancy", 32'(occupancy), 3);
      step();

      // Stall four cycles on a full chain, then resume.
      stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 16'h0077, 1'b1);
         sample();
         chk("stall in_ready", 32'(in_ready), 0);
         chk("stall out_valid", 32'(out_valid), 0);
         chk("stall occupancy", 32'(occupancy), 3);
         step();
      end
      stall = 1'b0;
      drive(1'b1, 16'h0077, 1'b1);
      sample();
      chk("resume out_data", 32'(out_data), 16'h0A01);
      step();
      drive(1'b1, 16'h0078, 1'b1); cyc();
      for (int k = 0; k < 5; k++) begin drive(1'b0, 16'h0, 1'b1); cyc(); end

      // Flush with stall on a full chain drops everything, including the offered 0x55.
      drive(1'b1, 16'h00C1, 1'b0); cyc();
      drive(1'b1, 16'h00C2, 1'b0); cyc();
      drive(1'b1, 16'h00C3, 1'b0); cyc();
      flush = 1'b1; stall = 1'b1;
      drive(1'b1, 16'h0055, 1'b1);
      sample();
      chk("flush in_ready", 32'(in_ready), 0);
      chk("flush out_valid", 32'(out_valid), 0);
      step();
      flush = 1'b0; stall = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 16'h0, 1'b1);
         sample();
         chk("post-flush occupancy", 32'(occupancy), 0);
         chk("post-flush out_valid", 32'(out_valid), 0);
         step();
      end
      for (int c = 0; c < 5; c++) begin
         drive(c == 0, 16'h0099, 1'b1);
         sample();
         if (c == 3) begin
            chk("post-flush new out_valid", 32'(out_valid), 1);
            chk("post-flush new out_data", 32'(out_data), 16'h0099);
         end
         step();
      end

      // Asynchronous reset mid-stream on a full chain, with stall and flush also high.
      drive(1'b1, 16'h00D1, 1'b0); cyc();
      drive(1'b1, 16'h00D2, 1'b0); cyc();
      drive(1'b1, 16'h00D3, 1'b0); cyc();
      chk("pre-reset occupancy", 32'(occupancy), 3);
      stall = 1'b1; flush = 1'b1;
      #2 reset = 1'b0;
      #1;
      chk("async reset out_valid", 32'(out_valid), 0);
      chk("async reset occupancy", 32'(occupancy), 0);
      chk("async reset out_data", 32'(out_data), 0);
      chk("async reset in_ready", 32'(in_ready), 0);
      mv = '0;
      sbq.delete();
      @(posedge clk); #1;
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      drive(1'b1, 16'h00E1, 1'b1); cyc();
      drive(1'b1, 16'h00E2, 1'b1); cyc();
      for (int k = 0; k < 4; k++) begin drive(1'b0, 16'h0, 1'b1); cyc(); end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
